systolic_mm_n: RTL and testbench
================================

# systolic_mm_n

Parametrised N×N output-stationary systolic matrix multiplier, successor to the fixed 3×3 SMM core. It computes Y = A·B for BW-bit operands, signed or unsigned, with valid/ready streaming on both input and output. Inputs arrive as outer-product beats (column k of A with row k of B). Results are emitted one row per handshake. It sits between the operand DMA and the result writeback path.

## Interface
- N, default 3: matrix dimension (N ≥ 2).
- BW, default 8: operand width.
- SIGNED, default 0: 1 = two's-complement operands and results; 0 = unsigned.
- ACC_W, default 2*BW + $clog2(N): accumulator/result element width; not to be overridden smaller.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  high only in LOAD.
- a_col  in  N*BW  A[i][k] at [i*BW +: BW].
- b_row  in  N*BW  B[k][j] at [j*BW +: BW].
- out_valid  out  1  result row valid.
- out_ready  in  1  result row accepted.
- y_row  out  N*ACC_W  Y[r][j] at [j*ACC_W +: ACC_W].
- y_row_idx  out  $clog2(N)  row index r of y_row.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, LOAD, DRAIN, OUT. Reset state is IDLE. All accumulators, skew registers and counters are cleared.
- IDLE → LOAD unconditionally on the next edge. The accumulators are already zero at this point.
- LOAD: in_ready=1. Each in_valid&in_ready edge is one beat k, counted 0..N-1. A cycle without in_valid injects zeros into the skew chains. Bubbles never corrupt the result.
- Skew: a_col element i is delayed i stages before entering row i. b_row element j is delayed j stages before entering column j.
- Each PE(i,j) adds a·b into its accumulator, then forwards a to the right and b downward, one register each.
- After the N-th beat is accepted: LOAD → DRAIN, and in_ready drops the next cycle. DRAIN lasts exactly 2N-1 cycles while zeros are injected. DRAIN → OUT.
- OUT: out_valid=1. y_row shows accumulator row y_row_idx, starting at 0. Each out_valid&out_ready edge increments y_row_idx.
- On the edge accepting row N-1: all accumulators clear, y_row_idx returns to 0, and the state goes → IDLE.
- Arithmetic: products are BW×BW → 2*BW bits, sign- or zero-extended per SIGNED, then summed into ACC_W bits. ACC_W guarantees no overflow for any inputs.
- In OUT, y_row and y_row_idx hold stable while out_valid && !out_ready.
- Reset mid-operation (any state) discards the matrix, and outputs return to reset values immediately.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, y_row=0, y_row_idx=0.
- in_ready rises one cycle after reset release (IDLE → LOAD).
- With beats accepted at edge e, all PE updates finish by edge e+2N-1. State is OUT and out_valid=1 after edge e+2N-1.
- Gapless throughput: one matrix per (N + (2N-1) + N + 1) cycles. For N=3 that is 12 cycles.
- in_valid outside LOAD is ignored; no data is consumed.
- out_ready outside OUT has no effect.

## Structure
- Package systolic_mm_pkg holds:
  - the state enum {IDLE, LOAD, DRAIN, OUT};
  - function acc_width(bw, n) returning 2*bw + $clog2(n);
  - helper function for the signed/unsigned extend.
- Sub-module systolic_pe (params BW, ACC_W, SIGNED) contains:
  - ports clk, rst_n, clr, a_in, b_in, a_out, b_out, acc;
  - a `generate` instantiates the N×N grid.
- The top level contains the FSM, beat/drain/row counters, skew shift registers and the output row mux.

## Test plan
- Identity: N=3, BW=8, A=I, B=[[1,2,3],[4,5,6],[7,8,9]], no stalls → rows {1,2,3},{4,5,6},{7,8,9} with y_row_idx 0,1,2. out_valid first high 5 cycles after the 3rd beat edge.
- Unsigned max: SIGNED=0, all operands 255 → every Y element 195075 (ACC_W=18).
- Signed: SIGNED=1, A all -128, B all -128 → 49152. Then A all -128, B all 127 → -48768.
- Bubbles and backpressure: insert 2 idle cycles between beats and hold out_ready low 3 cycles per row. The result must equal the gapless run, and y_row must be stable while stalled.
- Back-to-back: two different matrix pairs streamed consecutively. The second result must be correct, proving accumulators cleared and in_ready=0 during DRAIN/OUT.
- Reset mid-DRAIN: assert rst_n low → in_ready=0, out_valid=0, busy=0 asynchronously. After release, a fresh identity test passes.

Source files
------------

// File: rtl/systolic_mm_pkg.sv
// Shared definitions for the N x N output-stationary systolic multiplier.
//   state_t    : controller states (IDLE, LOAD, DRAIN, OUT)
//   acc_width  : minimum overflow-free accumulator width for bw-bit operands, n terms
//   ext_val    : sign- or zero-extends the low w bits of a value to EXT_W bits
package systolic_mm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int EXT_W = 128;

  function automatic int acc_width(input int bw, input int n);
    return 2 * bw + $clog2(n);
  endfunction

  // Bits at and above w are replaced by copies of bit w-1 (sgn=1) or by zero.
  function automatic logic [EXT_W-1:0] ext_val(input logic [EXT_W-1:0] v,
                                               input int w, input bit sgn);
    logic [EXT_W-1:0] hi_mask;
    hi_mask = {EXT_W{1'b1}} << w;
    if (sgn && (((v >> (w - 1)) & EXT_W'(1)) != '0)) return v | hi_mask;
    return v & ~hi_mask;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element of the systolic grid.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of accumulator and forwarding registers
//   a_in, b_in : operands arriving from the left / from above
//   a_out      : a_in registered, passed to the right neighbour
//   b_out      : b_in registered, passed to the neighbour below
//   acc        : running sum of a_in * b_in
module systolic_pe
  import systolic_mm_pkg::*;
#(
  parameter int BW     = 8,
  parameter int ACC_W  = 18,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [BW-1:0]    a_in,
  input  logic [BW-1:0]    b_in,
  output logic [BW-1:0]    a_out,
  output logic [BW-1:0]    b_out,
  output logic [ACC_W-1:0] acc
);

  logic [2*BW-1:0]  a_x;
  logic [2*BW-1:0]  b_x;
  logic [2*BW-1:0]  prod;
  logic [ACC_W-1:0] prod_ext;

  // Operands are widened to 2*BW first, so the 2*BW-bit product is exact
  // for both signed and unsigned interpretation.
  always_comb begin
    if (SIGNED != 0) begin
      a_x = {{BW{a_in[BW-1]}}, a_in};
      b_x = {{BW{b_in[BW-1]}}, b_in};
    end else begin
      a_x = {{BW{1'b0}}, a_in};
      b_x = {{BW{1'b0}}, b_in};
    end
    prod     = a_x * b_x;
    prod_ext = ACC_W'(ext_val(EXT_W'(prod), 2 * BW, SIGNED != 0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_mm_n.sv
// N x N output-stationary systolic matrix multiplier, Y = A * B.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : input beat handshake; beat k carries column k of A
//                        (a_col, A[i][k] at [i*BW +: BW]) and row k of B
//                        (b_row, B[k][j] at [j*BW +: BW])
//   out_valid/out_ready: result row handshake; y_row holds Y[r][j] at
//                        [j*ACC_W +: ACC_W], y_row_idx holds r
//   busy               : high in every state but IDLE
//   state_dbg          : current controller state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and y_row/y_row_idx hold while
// out_valid is high and out_ready is low.
module systolic_mm_n
  import systolic_mm_pkg::*;
#(
  parameter int N      = 3,
  parameter int BW     = 8,
  parameter int SIGNED = 0,
  parameter int ACC_W  = acc_width(BW, N)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*BW-1:0]          a_col,
  input  logic [N*BW-1:0]          b_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*ACC_W-1:0]       y_row,
  output logic [$clog2(N)-1:0]     y_row_idx,
  output logic                     busy,
  output logic [1:0]               state_dbg
);

  localparam int RW = $clog2(N);
  localparam int DW = $clog2(2 * N);

  state_t state, state_nxt;

  logic [RW-1:0] beat_cnt;
  logic [RW-1:0] row_idx;
  logic [DW-1:0] drain_cnt;
  logic          beat_fire, last_beat;
  logic          row_fire, last_row;
  logic          drain_done;
  logic          acc_clr;

  logic [BW-1:0]    a_inj [N];
  logic [BW-1:0]    b_inj [N];
  logic [BW-1:0]    a_h   [N][N];
  logic [BW-1:0]    b_v   [N][N];
  logic [ACC_W-1:0] acc_g [N][N];

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign y_row_idx = row_idx;

  assign beat_fire  = in_valid && in_ready;
  assign last_beat  = beat_fire && (beat_cnt == RW'(N - 1));
  assign row_fire   = out_valid && out_ready;
  assign last_row   = row_fire && (row_idx == RW'(N - 1));
  assign drain_done = (state == DRAIN) && (drain_cnt == DW'(2 * N - 2));
  assign acc_clr    = last_row;

  // ---------------- controller ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = LOAD;
      LOAD:    if (last_beat)  state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = OUT;
      OUT:     if (last_row)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      drain_cnt <= '0;
      row_idx   <= '0;
    end else begin
      if (last_beat)      beat_cnt <= '0;
      else if (beat_fire) beat_cnt <= beat_cnt + 1'b1;

      if (state == DRAIN && !drain_done) drain_cnt <= drain_cnt + 1'b1;
      else                               drain_cnt <= '0;

      if (last_row)      row_idx <= '0;
      else if (row_fire) row_idx <= row_idx + 1'b1;
    end
  end

  // ---------------- operand injection and skew ----------------
  // Anything other than an accepted beat injects zeros, so bubbles and the
  // drain phase contribute nothing to the sums.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_inj[i] = beat_fire ? a_col[i*BW +: BW] : '0;
      b_inj[i] = beat_fire ? b_row[i*BW +: BW] : '0;
    end
  end

  // Lane i is delayed i cycles so that A[i][k] and B[k][j] meet in PE(i,j)
  // on the same edge: both travel i + j register stages in total.
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_h[0][0] = a_inj[0];
      assign b_v[0][0] = b_inj[0];
    end else begin : g_delay
      logic [BW-1:0] a_sr [i];
      logic [BW-1:0] b_sr [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < i; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else if (acc_clr) begin
          for (int s = 0; s < i; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else begin
          a_sr[0] <= a_inj[i];
          b_sr[0] <= b_inj[i];
          for (int s = 1; s < i; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end
      assign a_h[i][0] = a_sr[i-1];
      assign b_v[0][i] = b_sr[i-1];
    end
  end

  // ---------------- PE grid ----------------
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [BW-1:0] a_fwd;
      logic [BW-1:0] b_fwd;

      systolic_pe #(
        .BW    (BW),
        .ACC_W (ACC_W),
        .SIGNED(SIGNED)
      ) u_pe (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (acc_clr),
        .a_in (a_h[i][j]),
        .b_in (b_v[i][j]),
        .a_out(a_fwd),
        .b_out(b_fwd),
        .acc  (acc_g[i][j])
      );

      // Operands leaving the right and bottom edges are simply dropped.
      if (j < N - 1) begin : g_a_pass
        assign a_h[i][j+1] = a_fwd;
      end else begin : g_a_end
        logic [BW-1:0] a_spill_unused;
        assign a_spill_unused = a_fwd;
      end

      if (i < N - 1) begin : g_b_pass
        assign b_v[i+1][j] = b_fwd;
      end else begin : g_b_end
        logic [BW-1:0] b_spill_unused;
        assign b_spill_unused = b_fwd;
      end
    end
  end

  // ---------------- output row mux ----------------
  // Only presented in OUT so partial sums never appear on y_row.
  always_comb begin
    y_row = '0;
    if (state == OUT) begin
      for (int j = 0; j < N; j++) begin
        y_row[j*ACC_W +: ACC_W] = acc_g[row_idx][j];
      end
    end
  end

endmodule

// File: tb/tb_systolic_mm_n.sv
module tb_systolic_mm_n;
  import systolic_mm_pkg::*;

  localparam int N     = 3;
  localparam int BW    = 8;
  localparam int ACC_W = 18;
  localparam int AW    = N * BW;
  localparam int YW    = N * ACC_W;
  localparam int RW    = $clog2(N);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs (unsigned and signed, shared stimulus) ----------------
  logic          in_valid, out_ready;
  logic [AW-1:0] a_col, b_row;
  logic          in_ready_u, out_valid_u, busy_u;
  logic          in_ready_s, out_valid_s, busy_s;
  logic [YW-1:0] y_row_u, y_row_s;
  logic [RW-1:0] idx_u, idx_s;
  logic [1:0]    dbg_u, dbg_s;

  systolic_mm_n #(.N(N), .BW(BW), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .a_col(a_col), .b_row(b_row), .out_valid(out_valid_u), .out_ready(out_ready),
    .y_row(y_row_u), .y_row_idx(idx_u), .busy(busy_u), .state_dbg(dbg_u));

  systolic_mm_n #(.N(N), .BW(BW), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a_col(a_col), .b_row(b_row), .out_valid(out_valid_s), .out_ready(out_ready),
    .y_row(y_row_s), .y_row_idx(idx_s), .busy(busy_s), .state_dbg(dbg_s));

  // ---------------- reference model and scoreboard ----------------
  int ma [N][N];   // operand byte patterns 0..255
  int mb [N][N];
  logic [YW-1:0] exp_u_q[$];
  logic [YW-1:0] exp_s_q[$];

  int pass_n = 0;
  int total_n = 0;

  // Plain matrix product of row r, operands read as unsigned or two's complement.
  function automatic logic [YW-1:0] exp_row(int r, bit sgn);
    logic [YW-1:0] row;
    row = '0;
    for (int j = 0; j < N; j++) begin
      int s;
      s = 0;
      for (int k = 0; k < N; k++) begin
        int a, b;
        a = ma[r][k];
        b = mb[k][j];
        if (sgn && a > 127) a -= 256;
        if (sgn && b > 127) b -= 256;
        s += a * b;
      end
      row[j*ACC_W +: ACC_W] = ACC_W'(s);
    end
    return row;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = i * N + j + 1;
      end
  endtask

  task automatic set_fill(int av, int bv);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = av;
        mb[i][j] = bv;
      end
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = $urandom_range(0, 255);
        mb[i][j] = $urandom_range(0, 255);
      end
  endtask

  // ---------------- driver tasks ----------------
  // Streams the current ma/mb as N beats with gap_lo..gap_hi junk bubbles
  // before each beat. Returns just after the edge accepting the last beat.
  task automatic send_matrix(int gap_lo, int gap_hi);
    int n;
    for (int r = 0; r < N; r++) begin
      exp_u_q.push_back(exp_row(r, 1'b0));
      exp_s_q.push_back(exp_row(r, 1'b1));
    end
    for (int k = 0; k < N; k++) begin
      repeat ($urandom_range(gap_lo, gap_hi)) begin
        @(negedge clk);
        in_valid  = 1'b0;
        a_col     = AW'($urandom());
        b_row     = AW'($urandom());
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n = 0;
      while (!in_ready_u && n < 50) begin
        in_valid = 1'b1;
        a_col    = AW'($urandom());
        b_row    = AW'($urandom());
        @(negedge clk);
        n++;
      end
      chk($sformatf("in_ready_beat%0d", k), 64'(in_ready_u), 64'd1);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
        a_col[i*BW +: BW] = BW'(ma[i][k]);
        b_row[i*BW +: BW] = BW'(mb[k][i]);
      end
      @(posedge clk);
    end
  endtask

  // Drains, optionally keeping in_valid high with junk, and checks latency.
  task automatic wait_result(bit junk);
    int last_e, n;
    @(negedge clk);
    last_e   = cyc;
    in_valid = junk;
    a_col    = AW'($urandom());
    b_row    = AW'($urandom());
    n = 0;
    while (!out_valid_u && n < 100) begin
      chk("in_ready_drain", 64'(in_ready_u), 64'd0);
      chk("busy_drain", 64'(busy_u), 64'd1);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("out_valid_rise", 64'(out_valid_u), 64'd1);
    chk("out_valid_rise_s", 64'(out_valid_s), 64'd1);
    chk("latency", 64'(cyc - last_e), 64'(2 * N - 1));
  endtask

  // Accepts the N rows, holding out_ready low stall_lo..stall_hi cycles each.
  task automatic collect(int stall_lo, int stall_hi);
    logic [YW-1:0] eu, es;
    int n;
    for (int r = 0; r < N; r++) begin
      eu = exp_u_q.pop_front();
      es = exp_s_q.pop_front();
      n = 0;
      while (!out_valid_u && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("out_valid_row%0d", r), 64'(out_valid_u), 64'd1);
      out_ready = 1'b0;
      repeat ($urandom_range(stall_lo, stall_hi)) begin
        chk($sformatf("stall_y_row%0d_u", r), 64'(y_row_u), 64'(eu));
        chk($sformatf("stall_idx%0d", r), 64'(idx_u), 64'(r));
        chk("in_ready_out", 64'(in_ready_u), 64'd0);
        @(negedge clk);
      end
      chk($sformatf("y_row%0d_u", r), 64'(y_row_u), 64'(eu));
      chk($sformatf("y_row%0d_s", r), 64'(y_row_s), 64'(es));
      chk($sformatf("idx%0d_u", r), 64'(idx_u), 64'(r));
      chk($sformatf("idx%0d_s", r), 64'(idx_s), 64'(r));
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk("busy_idle", 64'(busy_u), 64'd0);
    chk("out_valid_idle", 64'(out_valid_u), 64'd0);
    chk("idx_idle", 64'(idx_u), 64'd0);
    // Junk offered during IDLE must not be consumed.
    in_valid = 1'b1;
    a_col    = AW'($urandom());
    b_row    = AW'($urandom());
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_in_ready"}, 64'(in_ready_u), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid_u), 64'd0);
    chk({tag, "_busy"}, 64'(busy_u), 64'd0);
    chk({tag, "_y_row"}, 64'(y_row_u), 64'd0);
    chk({tag, "_idx"}, 64'(idx_u), 64'd0);
    chk({tag, "_in_ready_s"}, 64'(in_ready_s), 64'd0);
    chk({tag, "_out_valid_s"}, 64'(out_valid_s), 64'd0);
    chk({tag, "_busy_s"}, 64'(busy_s), 64'd0);
    chk({tag, "_y_row_s"}, 64'(y_row_s), 64'd0);
    chk({tag, "_state"}, 64'(dbg_u), 64'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_col = '0; b_row = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_release", 64'(in_ready_u), 64'd0);
    @(negedge clk);
    chk("in_ready_rise", 64'(in_ready_u), 64'd1);
    chk("busy_load", 64'(busy_u), 64'd1);

    // Identity, gapless
    set_identity();
    send_matrix(0, 0); wait_result(1'b0); collect(0, 0);

    // All 255: unsigned 195075 per element
    set_fill(255, 255);
    send_matrix(0, 0); wait_result(1'b1); collect(0, 0);

    // -128 * -128 and -128 * 127, back to back
    set_fill(128, 128);
    send_matrix(0, 0); wait_result(1'b1); collect(0, 0);
    set_fill(128, 127);
    send_matrix(0, 0); wait_result(1'b0); collect(0, 0);

    // Same random pair, gapless then with 2 bubbles per beat and 3 stalls per row
    set_random();
    send_matrix(0, 0); wait_result(1'b0); collect(0, 0);
    send_matrix(2, 2); wait_result(1'b0); collect(3, 3);

    // Randomised pairs, gaps and backpressure
    for (int t = 0; t < 6; t++) begin
      set_random();
      send_matrix(0, 2);
      wait_result(1'($urandom_range(0, 1)));
      collect(0, 2);
    end

    // Reset in the middle of DRAIN
    set_identity();
    send_matrix(0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("state_mid_drain", 64'(dbg_u), 64'(DRAIN));
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    exp_u_q.delete();
    exp_s_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    set_identity();
    send_matrix(0, 0); wait_result(1'b0); collect(1, 2);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
